alu_ctrl_mdu: RTL and testbench

- Next-generation ALU control for the pipelined MIPS core.
- Decodes a widened ALUOp (adds immediate-class ops) and an extended funct set.
- Registers the resulting 4-bit ALU code into the EX stage.
- Owns an iterative signed multiply/divide sequencer with HI/LO registers, raising a pipeline stall while busy or on a HI/LO hazard.
- Sits between the ID/EX pipeline register and the EX-stage ALU; the hazard unit ORs its stall output into the global stall.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/md_seq.sv | 116 +++++++++++
 rtl/alu_ctrl_mdu.sv | 103 ++++++++++
 tb/tb_alu_ctrl_mdu.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control codes, ALUOp/funct encodings and multiply/divide sequencer states.
// The EX-stage ALU imports the same codes so decode and execute cannot drift apart.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'd0;
    localparam logic [3:0] ALU_OR    = 4'd1;
    localparam logic [3:0] ALU_ADD   = 4'd2;
    localparam logic [3:0] ALU_XOR   = 4'd3;
    localparam logic [3:0] ALU_SUB   = 4'd6;
    localparam logic [3:0] ALU_SLT   = 4'd7;
    localparam logic [3:0] ALU_SHIFT = 4'd8;
    localparam logic [3:0] ALU_MFHI  = 4'd9;
    localparam logic [3:0] ALU_MFLO  = 4'd10;
    localparam logic [3:0] ALU_LUI   = 4'd11;
    localparam logic [3:0] ALU_NOR   = 4'd12;
    localparam logic [3:0] ALU_MULT  = 4'd13;
    localparam logic [3:0] ALU_DIV   = 4'd14;

    localparam logic [2:0] AOP_MEM   = 3'b000;
    localparam logic [2:0] AOP_BEQ   = 3'b001;
    localparam logic [2:0] AOP_RTYPE = 3'b010;
    localparam logic [2:0] AOP_ANDI  = 3'b011;
    localparam logic [2:0] AOP_ORI   = 3'b100;
    localparam logic [2:0] AOP_SLTI  = 3'b101;
    localparam logic [2:0] AOP_LUI   = 3'b110;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SHIFT = 6'b101111;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_DIV   = 6'b011010;

    typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_t;

endpackage

// File: rtl/md_seq.sv
// Iterative signed multiply/divide sequencer: one radix-2 step per cycle on magnitudes,
// sign correction and HI/LO write in the DONE state.
module md_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH);

    md_state_t        state;
    logic [CNT_W-1:0] cnt;
    // acc_hi/acc_lo: partial product and multiplier for mult, remainder and quotient for div
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd_b;
    logic             div_q, neg_res, neg_rem, b_zero;
    logic [WIDTH:0]   sum, shifted, diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] hi_res, lo_res;

    function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] v);
        return n ? -v : v;
    endfunction

    assign sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
    assign shifted = {acc_hi, acc_lo[WIDTH-1]};
    assign diff    = shifted - {1'b0, opnd_b};

    always_comb begin
        prod_fix = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        hi_res   = div_q ? neg_if(neg_rem, acc_hi) : prod_fix[2*WIDTH-1:WIDTH];
        lo_res   = div_q ? (b_zero ? '1 : neg_if(neg_res, acc_lo)) : prod_fix[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= MD_IDLE;
            cnt     <= '0;
            md_busy <= 1'b0;
            md_done <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            md_done <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        state   <= MD_RUN;
                        md_busy <= 1'b1;
                        cnt     <= '0;
                    end
                end
                MD_RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH-1)) begin
                        state   <= MD_DONE;
                        md_busy <= 1'b0;
                    end
                end
                MD_DONE: begin
                    md_done <= 1'b1;
                    hi      <= hi_res;
                    lo      <= lo_res;
                    if (start) begin
                        state   <= MD_RUN;
                        md_busy <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        state <= MD_IDLE;
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

    // Datapath: operand capture on accept, then one shift-add or restoring-subtract step per RUN cycle
    always_ff @(posedge clk) begin
        if (start && state != MD_RUN) begin
            acc_hi  <= '0;
            acc_lo  <= op_div ? abs_val(src_a) : abs_val(src_b);
            opnd_b  <= op_div ? abs_val(src_b) : abs_val(src_a);
            div_q   <= op_div;
            neg_res <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
            neg_rem <= src_a[WIDTH-1];
            b_zero  <= (src_b == '0);
        end else if (state == MD_RUN) begin
            if (div_q) begin
                if (!diff[WIDTH]) begin
                    acc_hi <= diff[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                end else begin
                    acc_hi <= shifted[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_hi <= sum[WIDTH:1];
                acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// ALU control decode with registered EX-stage code, plus the multiply/divide sequencer
// and the stall it raises for HI/LO hazards.
module alu_ctrl_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int ALUOP_W = 3,
    parameter int CTRL_W  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [ALUOP_W-1:0] alu_op,
    input  logic [5:0]         funct,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    input  logic               ex_flush,
    output logic [CTRL_W-1:0]  alu_ctrl,
    output logic               ex_valid,
    output logic               stall,
    output logic               md_busy,
    output logic               md_done,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);
    logic [3:0] code_p0;
    logic       md_start_p0, hilo_rd_p0, op_div_p0, accept_p0;

    always_comb begin
        code_p0     = ALU_AND;
        md_start_p0 = 1'b0;
        hilo_rd_p0  = 1'b0;
        op_div_p0   = 1'b0;
        case (alu_op)
            ALUOP_W'(AOP_MEM):  code_p0 = ALU_ADD;
            ALUOP_W'(AOP_BEQ):  code_p0 = ALU_SUB;
            ALUOP_W'(AOP_ANDI): code_p0 = ALU_AND;
            ALUOP_W'(AOP_ORI):  code_p0 = ALU_OR;
            ALUOP_W'(AOP_SLTI): code_p0 = ALU_SLT;
            ALUOP_W'(AOP_LUI):  code_p0 = ALU_LUI;
            ALUOP_W'(AOP_RTYPE): begin
                case (funct)
                    F_ADD:   code_p0 = ALU_ADD;
                    F_SUB:   code_p0 = ALU_SUB;
                    F_AND:   code_p0 = ALU_AND;
                    F_OR:    code_p0 = ALU_OR;
                    F_XOR:   code_p0 = ALU_XOR;
                    F_NOR:   code_p0 = ALU_NOR;
                    F_SLT:   code_p0 = ALU_SLT;
                    F_SHIFT: code_p0 = ALU_SHIFT;
                    F_MFHI: begin
                        code_p0    = ALU_MFHI;
                        hilo_rd_p0 = 1'b1;
                    end
                    F_MFLO: begin
                        code_p0    = ALU_MFLO;
                        hilo_rd_p0 = 1'b1;
                    end
                    F_MULT: begin
                        code_p0     = ALU_MULT;
                        md_start_p0 = 1'b1;
                    end
                    F_DIV: begin
                        code_p0     = ALU_DIV;
                        md_start_p0 = 1'b1;
                        op_div_p0   = 1'b1;
                    end
                    default: code_p0 = ALU_AND;
                endcase
            end
            default: code_p0 = ALU_AND;
        endcase
    end

    // A new start or HI/LO read waits in ID while the sequencer is still iterating
    assign stall     = id_valid & md_busy & (md_start_p0 | hilo_rd_p0);
    assign accept_p0 = id_valid & md_start_p0 & ~stall & ~ex_flush;

    // ID -> EX stage boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_ctrl <= '0;
            ex_valid <= 1'b0;
        end else if (!stall) begin
            alu_ctrl <= ex_flush ? '0 : CTRL_W'(code_p0);
            ex_valid <= id_valid & ~ex_flush;
        end
    end

    md_seq #(.WIDTH(WIDTH)) u_md_seq (
        .clk     (clk),
        .reset   (reset),
        .start   (accept_p0),
        .op_div  (op_div_p0),
        .src_a   (src_a),
        .src_b   (src_b),
        .md_busy (md_busy),
        .md_done (md_done),
        .hi      (hi),
        .lo      (lo)
    );

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Bench for alu_ctrl_mdu: table-driven decode vectors plus a HI/LO scoreboard fed by a
// longint reference model and popped on every md_done pulse.
module tb_alu_ctrl_mdu;

    typedef struct {
        logic [2:0] op;
        logic [5:0] fn;
        logic [3:0] exp;
    } dec_vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } md_exp_t;

    logic        clk = 1'b0;
    logic        reset, id_valid, ex_flush;
    logic [2:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] src_a, src_b, hi, lo;
    logic [3:0]  alu_ctrl;
    logic        ex_valid, stall, md_busy, md_done;

    int          errors = 0;
    int          checks = 0;
    md_exp_t     sb[$];
    dec_vec_t    dvec[18];

    alu_ctrl_mdu #(.WIDTH(32), .ALUOP_W(3), .CTRL_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .id_valid (id_valid),
        .alu_op   (alu_op),
        .funct    (funct),
        .src_a    (src_a),
        .src_b    (src_b),
        .ex_flush (ex_flush),
        .alu_ctrl (alu_ctrl),
        .ex_valid (ex_valid),
        .stall    (stall),
        .md_busy  (md_busy),
        .md_done  (md_done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic md_exp_t model(input logic [31:0] a, input logic [31:0] b, input logic div);
        md_exp_t r;
        longint  pa, pb, p, q, rm;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        if (!div) begin
            p    = pa * pb;
            r.hi = p[63:32];
            r.lo = p[31:0];
        end else if (b == 32'd0) begin
            r.lo = 32'hFFFF_FFFF;
            r.hi = a;
        end else begin
            q    = pa / pb;
            rm   = pa % pb;
            r.lo = q[31:0];
            r.hi = rm[31:0];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!reset && md_done === 1'b1) begin : sb_pop
            md_exp_t e;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL md_unexpected_done: got done with empty scoreboard, expected none");
            end else begin
                e = sb.pop_front();
                chk("md_hi", {32'd0, hi}, {32'd0, e.hi});
                chk("md_lo", {32'd0, lo}, {32'd0, e.lo});
            end
        end
    end

    task automatic run_md(input logic [31:0] a, input logic [31:0] b, input logic div,
                          input logic flush_run);
        int cyc, busy;
        id_valid = 1'b1;
        alu_op   = 3'b010;
        funct    = div ? 6'b011010 : 6'b011000;
        src_a    = a;
        src_b    = b;
        ex_flush = 1'b0;
        @(posedge clk); #1;
        sb.push_back(model(a, b, div));
        id_valid = 1'b0;
        alu_op   = 3'b000;
        funct    = 6'd0;
        ex_flush = flush_run;
        cyc  = 0;
        busy = 0;
        while (md_done !== 1'b1 && cyc < 60) begin
            if (md_busy === 1'b1) busy++;
            @(posedge clk); #1;
            cyc++;
        end
        ex_flush = 1'b0;
        chk("md_latency", 64'(cyc), 64'd33);
        chk("md_busy_cycles", 64'(busy), 64'd32);
        @(posedge clk); #1;
        chk("md_done_pulse", {63'd0, md_done}, 64'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] ra, rb, exp_lo;
        logic        rop;
        int          guard;

        dvec[0]  = '{3'b010, 6'b100000, 4'd2};
        dvec[1]  = '{3'b010, 6'b100010, 4'd6};
        dvec[2]  = '{3'b010, 6'b100100, 4'd0};
        dvec[3]  = '{3'b010, 6'b100101, 4'd1};
        dvec[4]  = '{3'b010, 6'b100110, 4'd3};
        dvec[5]  = '{3'b010, 6'b100111, 4'd12};
        dvec[6]  = '{3'b010, 6'b101010, 4'd7};
        dvec[7]  = '{3'b010, 6'b101111, 4'd8};
        dvec[8]  = '{3'b010, 6'b010000, 4'd9};
        dvec[9]  = '{3'b010, 6'b010010, 4'd10};
        dvec[10] = '{3'b010, 6'b111111, 4'd0};
        dvec[11] = '{3'b000, 6'b100010, 4'd2};
        dvec[12] = '{3'b001, 6'b000000, 4'd6};
        dvec[13] = '{3'b011, 6'b100000, 4'd0};
        dvec[14] = '{3'b100, 6'b000000, 4'd1};
        dvec[15] = '{3'b101, 6'b000000, 4'd7};
        dvec[16] = '{3'b110, 6'b000000, 4'd11};
        dvec[17] = '{3'b111, 6'b100000, 4'd0};

        reset    = 1'b1;
        id_valid = 1'b0;
        ex_flush = 1'b0;
        alu_op   = 3'b000;
        funct    = 6'd0;
        src_a    = 32'd0;
        src_b    = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_alu_ctrl", {60'd0, alu_ctrl}, 64'd0);
        chk("rst_ex_valid", {63'd0, ex_valid}, 64'd0);
        chk("rst_md_busy", {63'd0, md_busy}, 64'd0);
        chk("rst_md_done", {63'd0, md_done}, 64'd0);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            id_valid = 1'b1;
            alu_op   = dvec[i].op;
            funct    = dvec[i].fn;
            @(posedge clk); #1;
            chk($sformatf("dec_ctrl_%0d", i), {60'd0, alu_ctrl}, {60'd0, dvec[i].exp});
            chk($sformatf("dec_valid_%0d", i), {63'd0, ex_valid}, 64'd1);
            chk($sformatf("dec_stall_%0d", i), {63'd0, stall}, 64'd0);
        end
        id_valid = 1'b0;
        alu_op   = 3'b000;
        funct    = 6'd0;
        @(posedge clk); #1;
        chk("idle_ex_valid", {63'd0, ex_valid}, 64'd0);

        run_md(-32'sd3, 32'sd7, 1'b0, 1'b0);
        chk("mult_m3x7_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        chk("mult_m3x7_lo", {32'd0, lo}, 64'hFFFF_FFEB);
        run_md(-32'sd7, 32'sd2, 1'b1, 1'b0);
        chk("div_m7d2_lo", {32'd0, lo}, 64'hFFFF_FFFD);
        chk("div_m7d2_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        run_md(32'd5, 32'd0, 1'b1, 1'b0);
        chk("div_by0_lo", {32'd0, lo}, 64'hFFFF_FFFF);
        chk("div_by0_hi", {32'd0, hi}, 64'h5);
        run_md(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        chk("div_minneg_lo", {32'd0, lo}, 64'h8000_0000);
        chk("div_minneg_hi", {32'd0, hi}, 64'h0);
        run_md(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        run_md(32'd100, -32'sd7, 1'b1, 1'b0);
        run_md(32'd12345, -32'sd678, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            ra  = $urandom;
            rb  = $urandom;
            rop = 1'($urandom_range(0, 1));
            run_md(ra, rb, rop, 1'b0);
        end

        // Flushed start is never accepted
        id_valid = 1'b1;
        alu_op   = 3'b010;
        funct    = 6'b011000;
        src_a    = 32'd9;
        src_b    = 32'd9;
        ex_flush = 1'b1;
        @(posedge clk); #1;
        chk("flush_busy", {63'd0, md_busy}, 64'd0);
        chk("flush_ex_valid", {63'd0, ex_valid}, 64'd0);
        chk("flush_alu_ctrl", {60'd0, alu_ctrl}, 64'd0);
        id_valid = 1'b0;
        ex_flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("flush_still_idle", {63'd0, md_busy}, 64'd0);
        chk("flush_no_done", {63'd0, md_done}, 64'd0);

        // mflo in ID while busy stalls until the product is available
        id_valid = 1'b1;
        alu_op   = 3'b010;
        funct    = 6'b011000;
        src_a    = 32'd1234;
        src_b    = -32'sd77;
        @(posedge clk); #1;
        sb.push_back(model(32'd1234, -32'sd77, 1'b0));
        exp_lo = model(32'd1234, -32'sd77, 1'b0).lo;
        funct  = 6'b010010;
        src_a  = 32'd0;
        src_b  = 32'd0;
        #1;
        guard = 0;
        while (md_busy === 1'b1 && guard < 40) begin
            chk("mflo_stall", {63'd0, stall}, 64'd1);
            chk("mflo_hold", {60'd0, alu_ctrl}, 64'd13);
            @(posedge clk); #1;
            guard++;
        end
        chk("mflo_stall_cycles", 64'(guard), 64'd32);
        chk("mflo_release", {63'd0, stall}, 64'd0);
        @(posedge clk); #1;
        chk("mflo_done", {63'd0, md_done}, 64'd1);
        chk("mflo_alu_ctrl", {60'd0, alu_ctrl}, 64'd10);
        chk("mflo_lo", {32'd0, lo}, {32'd0, exp_lo});
        id_valid = 1'b0;
        alu_op   = 3'b000;
        funct    = 6'd0;
        @(posedge clk); #1;

        // Asynchronous reset at step 10 of a divide discards it
        id_valid = 1'b1;
        alu_op   = 3'b010;
        funct    = 6'b011010;
        src_a    = -32'sd100;
        src_b    = 32'd7;
        @(posedge clk); #1;
        id_valid = 1'b0;
        alu_op   = 3'b000;
        funct    = 6'd0;
        repeat (9) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_busy", {63'd0, md_busy}, 64'd0);
        chk("arst_done", {63'd0, md_done}, 64'd0);
        chk("arst_hi", {32'd0, hi}, 64'd0);
        chk("arst_lo", {32'd0, lo}, 64'd0);
        chk("arst_alu_ctrl", {60'd0, alu_ctrl}, 64'd0);
        chk("arst_ex_valid", {63'd0, ex_valid}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_md(-32'sd9, 32'd11, 1'b0, 1'b0);
        chk("post_rst_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        chk("post_rst_lo", {32'd0, lo}, 64'hFFFF_FF9D);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
